// File: rtl/ex_muldiv_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ex_muldiv_ctrl_if : EX-stage <-> multiply/divide sequencer bundle  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ex_muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_read;
  logic        mt_hi;
  logic        mt_lo;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic        stall_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, mf_read, mt_hi, mt_lo, mt_data,
    input  busy, done, stall_out, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, mf_read, mt_hi, mt_lo, mt_data,
    output busy, done, stall_out, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ex_muldiv_ctrl : iterative 32x32 MULT/DIV sequencer with HI/LO     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ex_muldiv_ctrl (
  input  wire logic       CLK,
  input  wire logic       RESET,
  ex_muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

  localparam logic [4:0] LAST_ITER = 5'd31;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_trial;
  logic [32:0] div_diff;
  logic        div_fits;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Operand sign/magnitude; negating 0x80000000 yields 0x80000000, which is
  // the correct magnitude when read as unsigned.
  always_comb begin
    rs_neg = bus.op[0] & bus.rs_val[31];
    rt_neg = bus.op[0] & bus.rt_val[31];
    rs_mag = rs_neg ? (~bus.rs_val + 32'd1) : bus.rs_val;
    rt_mag = rt_neg ? (~bus.rt_val + 32'd1) : bus.rt_val;
  end

  // One shift-add or restoring-divide step on the 64-bit accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_trial = acc_q[63:31];
    div_fits  = (div_trial >= {1'b0, opnd_q});
    div_diff  = div_trial - {1'b0, opnd_q};
    div_next  = div_fits ? {div_diff[31:0], acc_q[30:0], 1'b1}
                         : {div_trial[31:0], acc_q[30:0], 1'b0};
  end

  // Sign correction: remainder follows the dividend, quotient/product
  // follow the XOR of the operand signs.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          sign_a_d = rs_neg;
          sign_b_d = rt_neg;
          cnt_d    = 5'd0;
          if (bus.op[1]) begin
            opnd_d = rt_mag;
            acc_d  = {32'd0, rs_mag};
          end else begin
            opnd_d = rs_mag;
            acc_d  = {32'd0, rt_mag};
          end
          state_d = S_CALC;
        end else begin
          if (bus.mt_hi) hi_d = bus.mt_data;
          if (bus.mt_lo) lo_d = bus.mt_data;
        end
      end

      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) state_d = S_FIXUP;
      end

      S_FIXUP: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.stall_out = bus.busy & (bus.start | bus.mf_read | bus.mt_hi | bus.mt_lo);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule
`default_nettype wire
